// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: debounce state encodings and default debounce interval
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        DB_IDLE       = 2'd0,
        DB_PRESS_WAIT = 2'd1,
        DB_HELD       = 2'd2,
        DB_REL_WAIT   = 2'd3
    } db_state_t;

    localparam int DB_TICKS_DEFAULT = 1_000_000;

endpackage

// File: rtl/input_conditioner_debounce_fsm.sv
// debounce_fsm: one channel of 2-flop synchroniser, stability counter and debounce FSM
module debounce_fsm
    import input_conditioner_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEFAULT
) (
    input  logic Clock,
    input  logic Reset,
    input  logic i_raw,
    output logic level,
    output logic press,
    output logic o_fire
);

    localparam int CW = $clog2(DB_TICKS);
    localparam logic [CW-1:0] LAST = CW'(DB_TICKS - 1);

    logic          r_s1;
    logic          r_s2;
    db_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          w_last;

    assign w_last = r_cnt == LAST;
    // o_fire is high in the cycle whose closing edge registers the press pulse
    assign o_fire = r_state == DB_PRESS_WAIT && r_s2 && w_last;
    assign level  = r_level;
    assign press  = r_press;

    // Synchronise the raw input, then step the debounce FSM on the synchronised level
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= DB_IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            r_press <= o_fire;
            case (r_state)
                DB_IDLE: if (r_s2) begin
                    r_state <= DB_PRESS_WAIT;
                    r_cnt   <= '0;
                end
                DB_PRESS_WAIT: if (!r_s2) begin
                    r_state <= DB_IDLE;
                    r_cnt   <= '0;
                end else if (w_last) begin
                    r_state <= DB_HELD;
                    r_cnt   <= '0;
                    r_level <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                DB_HELD: if (!r_s2) begin
                    r_state <= DB_REL_WAIT;
                    r_cnt   <= '0;
                end
                DB_REL_WAIT: if (r_s2) begin
                    r_state <= DB_HELD;
                    r_cnt   <= '0;
                end else if (w_last) begin
                    r_state <= DB_IDLE;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= DB_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronise, debounce and capture board switches/buttons; SAMPLE_LATCH_EN latches Din on Sample
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEFAULT,
    parameter int NBTN     = 3
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [7:0]      SwIn,
    input  logic            SampleIn,
    input  logic [NBTN-1:0] BtnIn,
    output logic [7:0]      Din,
    output logic            Sample,
    output logic [NBTN-1:0] Btns,
    output logic [NBTN-1:0] BtnPress
);

    logic [7:0]    r_sw_s1;
    logic [7:0]    r_sw_s2;
    logic [NBTN:0] w_raw;
    logic [NBTN:0] w_level;
    logic [NBTN:0] w_press;
    logic [NBTN:0] w_fire;
    logic          w_unused;

    // Channel 0 is the Sample button, channels 1..NBTN are the user buttons
    assign w_raw    = {BtnIn, SampleIn};
    assign Sample   = w_press[0];
    assign Btns     = w_level[NBTN:1];
    assign BtnPress = w_press[NBTN:1];

    genvar i;
    generate
        for (i = 0; i <= NBTN; i++) begin : g_ch
            debounce_fsm #(.DB_TICKS(DB_TICKS)) u_db (
                .Clock  (Clock),
                .Reset  (Reset),
                .i_raw  (w_raw[i]),
                .level  (w_level[i]),
                .press  (w_press[i]),
                .o_fire (w_fire[i])
            );
        end
    endgenerate

    // Switches are only synchronised; they are sampled as a byte, never debounced
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= SwIn;
            r_sw_s2 <= r_sw_s1;
        end
    end

`ifdef SAMPLE_LATCH_EN
    logic [7:0] r_din;

    // Capture on the same edge that raises Sample so Din and Sample are valid together
    always_ff @(posedge Clock) begin
        if (Reset) r_din <= '0;
        else if (w_fire[0]) r_din <= r_sw_s2;
    end

    assign Din      = r_din;
    assign w_unused = ^{w_level[0], w_fire[NBTN:1]};
`else
    assign Din      = r_sw_s2;
    assign w_unused = ^{w_level[0], w_fire};
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed checks of debounce timing, glitch rejection, capture and reset
module tb_input_conditioner;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] SwIn = 8'h00;
    logic       SampleIn = 1'b0;
    logic [2:0] BtnIn = 3'b000;
    logic [7:0] Din;
    logic       Sample;
    logic [2:0] Btns;
    logic [2:0] BtnPress;

    int errors = 0;
    int checks = 0;

    input_conditioner #(.DB_TICKS(8), .NBTN(3)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .SwIn     (SwIn),
        .SampleIn (SampleIn),
        .BtnIn    (BtnIn),
        .Din      (Din),
        .Sample   (Sample),
        .Btns     (Btns),
        .BtnPress (BtnPress)
    );

    always #5 Clock = ~Clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        SwIn = 8'h5A;
        SampleIn = 1'b1;
        BtnIn = 3'b111;
        tick(3);
        checks++;
        if ({Din, Sample, Btns, BtnPress} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got Din=%h Sample=%b Btns=%b BtnPress=%b, want all zero", Din, Sample, Btns, BtnPress);
        end
        SwIn = 8'h00;
        SampleIn = 1'b0;
        BtnIn = 3'b000;
        tick(1);
        Reset = 1'b0;
    endtask

    task automatic test_clean_press;
        SampleIn = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            checks++;
            if (Sample !== (k == 11)) begin
                errors++;
                $display("FAIL clean_press edge %0d: Sample=%b want %b", k, Sample, k == 11);
            end
        end
        SampleIn = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            checks++;
            if (Sample !== 1'b0) begin
                errors++;
                $display("FAIL clean_release edge %0d: Sample=%b want 0", k, Sample);
            end
        end
    endtask

    task automatic test_glitch;
        BtnIn[1] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (k == 5) BtnIn[1] = 1'b0;
            checks++;
            if (BtnPress !== 3'b000 || Btns !== 3'b000) begin
                errors++;
                $display("FAIL glitch edge %0d: BtnPress=%b Btns=%b want 000/000", k, BtnPress, Btns);
            end
        end
    endtask

    task automatic test_release_bounce;
        int pulses = 0;
        BtnIn[0] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            pulses += int'(BtnPress[0]);
        end
        checks++;
        if (Btns[0] !== 1'b1) begin
            errors++;
            $display("FAIL bounce_held_level: Btns[0]=%b want 1", Btns[0]);
        end
        BtnIn[0] = 1'b0;
        tick(3);
        pulses += int'(BtnPress[0]);
        BtnIn[0] = 1'b1;
        tick(1);
        pulses += int'(BtnPress[0]);
        BtnIn[0] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            pulses += int'(BtnPress[0]);
            checks++;
            if (Btns[0] !== (k < 11)) begin
                errors++;
                $display("FAIL bounce_release edge %0d: Btns[0]=%b want %b", k, Btns[0], k < 11);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL bounce_pulse_count: got %0d pulses want 1", pulses);
        end
    endtask

    task automatic test_capture;
        SwIn = 8'hA5;
        tick(3);
        SampleIn = 1'b1;
        tick(11);
        checks++;
        if (Sample !== 1'b1 || Din !== 8'hA5) begin
            errors++;
            $display("FAIL capture_strobe: Sample=%b Din=%h want 1/a5", Sample, Din);
        end
        SwIn = 8'h3C;
        for (int k = 1; k <= 4; k++) begin
            logic [7:0] exp_din;
            tick(1);
`ifdef SAMPLE_LATCH_EN
            exp_din = 8'hA5;
`else
            exp_din = (k >= 2) ? 8'h3C : 8'hA5;
`endif
            checks++;
            if (Din !== exp_din) begin
                errors++;
                $display("FAIL capture_hold edge %0d: Din=%h want %h", k, Din, exp_din);
            end
        end
        SampleIn = 1'b0;
        tick(14);
    endtask

    task automatic test_reset_midcount;
        BtnIn[2] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            checks++;
            if (BtnPress !== 3'b000) begin
                errors++;
                $display("FAIL midcount_pre edge %0d: BtnPress=%b want 000", k, BtnPress);
            end
        end
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick(1);
            checks++;
            if (BtnPress[2] !== (k == 11)) begin
                errors++;
                $display("FAIL midcount_post edge %0d: BtnPress[2]=%b want %b", k, BtnPress[2], k == 11);
            end
        end
        BtnIn[2] = 1'b0;
        tick(14);
    endtask

    task automatic test_simultaneous;
        BtnIn = 3'b101;
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            checks++;
            if (BtnPress !== ((k == 11) ? 3'b101 : 3'b000) || Btns !== ((k >= 11) ? 3'b101 : 3'b000)) begin
                errors++;
                $display("FAIL simultaneous edge %0d: BtnPress=%b Btns=%b", k, BtnPress, Btns);
            end
        end
        BtnIn = 3'b000;
        tick(14);
        checks++;
        if (Btns !== 3'b000) begin
            errors++;
            $display("FAIL simultaneous_release: Btns=%b want 000", Btns);
        end
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_glitch;
        test_release_bounce;
        test_capture;
        test_reset_midcount;
        test_simultaneous;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
